gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter STEP_CYCLES, default 4, giving the dwell cycles per test vector (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1, the single system clock (rising edge).
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, sweep request, sampled in IDLE only.
REQ-005 The module SHALL have port abort, input, 1, synchronous sweep cancel.
REQ-006 The module SHALL have port manual, input, 1, pass-through enable, effective in IDLE only.
REQ-007 The module SHALL have ports SW0 and SW1, input, 1 each, manual operand switches.
REQ-008 The module SHALL have port SW2, input, 3, manual opcode switches.
REQ-009 The module SHALL have ports mux_a and mux_b, output, 1 each, operands driven to the external gate mux.
REQ-010 The module SHALL have port mux_sel, output, 3, opcode driven to the external gate mux.
REQ-011 The module SHALL have port mux_y, input, 1, gate mux result (combinational from mux_a/mux_b/mux_sel).
REQ-012 The module SHALL have port LED, output, 1, registered copy of mux_y.
REQ-013 The module SHALL have ports busy and done, output, 1 each, sweep active / one-cycle completion pulse.
REQ-014 The module SHALL have port table_out, output, 32, captured truth table, bit index = op*4 + {b,a}.
REQ-015 The module SHALL have port mismatch_cnt, output, 6, count of captured bits differing from golden.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, DONE; IDLE->APPLY on start=1 and abort=0; APPLY->DONE after vector 31 is sampled; DONE->IDLE unconditionally after one cycle.
REQ-017 In IDLE with manual=1, mux_a/mux_b/mux_sel SHALL equal SW0/SW1/SW2 combinationally; with manual=0 they SHALL be 0/0/0.
REQ-018 On IDLE->APPLY, the module SHALL clear table_out and mismatch_cnt, set op=0, vec=0, dwell=0, and assert busy from the next cycle.
REQ-019 In APPLY, the module SHALL drive mux_sel=op, mux_a=vec[0], mux_b=vec[1] for exactly STEP_CYCLES cycles per vector.
REQ-020 On the last dwell cycle, the module SHALL write mux_y into table_out[op*4+vec] and increment mismatch_cnt if mux_y differs from the golden value.
REQ-021 The golden values per op SHALL be: 0 ~a, 1 a, 2 a XNOR b, 3 a XOR b, 4 a|b, 5 ~(a|b), 6 a&b, 7 ~(a&b).
REQ-022 Vector order SHALL be vec 0..3 within each op, then op 0..7; one sweep SHALL occupy exactly 32*STEP_CYCLES APPLY cycles.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 0; table_out and mismatch_cnt SHALL hold until the next accepted start.
REQ-024 start SHALL be ignored while busy=1 or during DONE.
REQ-025 manual SHALL be ignored outside IDLE.
REQ-026 abort=1 in APPLY SHALL return the FSM to IDLE on the next edge with busy=0, no done pulse, and partial table_out/mismatch_cnt retained.
REQ-027 If start and abort are both 1 in IDLE, abort SHALL win and no sweep SHALL start.
REQ-028 mismatch_cnt SHALL not wrap; its maximum reachable value is 32.
REQ-029 LED SHALL register mux_y every cycle in all states.

Reset
REQ-030 While rst_n=0, the module SHALL force state=IDLE, busy=0, done=0, LED=0, table_out=0, mismatch_cnt=0, and internal op/vec/dwell=0, asynchronously.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep; after release the module SHALL wait in IDLE for a new start.

Verification
REQ-032 Correct mux model, STEP_CYCLES=4, pulse start: busy=1 for 128 cycles, then done pulse, table_out=0x781E69A5, mismatch_cnt=0.
REQ-033 Stuck-at-0 mux_y, one sweep: table_out=0x00000000, mismatch_cnt=16.
REQ-034 Stuck-at-1 mux_y, one sweep: table_out=0xFFFFFFFF, mismatch_cnt=16.
REQ-035 Abort after 10 APPLY cycles (STEP_CYCLES=4): IDLE next cycle, no done pulse, table_out[1:0]=2'b01, mismatch_cnt=0.
REQ-036 Manual=1 in IDLE with SW2=3, SW0=1, SW1=0: mux_sel=3, mux_a=1, mux_b=0, LED=1 one cycle later; manual toggled during a sweep has no effect on mux outputs.
REQ-037 Reset asserted at APPLY cycle 50: busy, done, LED, table_out, mismatch_cnt all 0 immediately; a second start after release completes a full sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all 32 operand/opcode vectors through an external gate mux, captures the
// resulting truth table and counts bits that differ from the golden gate behaviour.
module gate_sweep_ctrl #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        manual,
    input  logic        SW0,
    input  logic        SW1,
    input  logic [2:0]  SW2,
    output logic        mux_a,
    output logic        mux_b,
    output logic [2:0]  mux_sel,
    input  logic        mux_y,
    output logic        LED,
    output logic        busy,
    output logic        done,
    output logic [31:0] table_out,
    output logic [5:0]  mismatch_cnt
);

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    localparam logic [7:0] LastDwell = 8'(STEP_CYCLES - 1);

    state_e     state;
    logic [2:0] op;
    logic [1:0] vec;
    logic [7:0] dwell;
    logic       golden;
    logic [4:0] idx;

    assign idx = {op, vec};

    always_comb begin
        golden = 1'b0;
        unique case (op)
            3'd0: golden = ~vec[0];
            3'd1: golden = vec[0];
            3'd2: golden = ~(vec[0] ^ vec[1]);
            3'd3: golden = vec[0] ^ vec[1];
            3'd4: golden = vec[0] | vec[1];
            3'd5: golden = ~(vec[0] | vec[1]);
            3'd6: golden = vec[0] & vec[1];
            3'd7: golden = ~(vec[0] & vec[1]);
            default: golden = 1'b0;
        endcase
    end

    // Switch pass-through only while idle; the sweep owns the mux otherwise.
    always_comb begin
        mux_a   = 1'b0;
        mux_b   = 1'b0;
        mux_sel = 3'd0;
        if (state == StApply) begin
            mux_a   = vec[0];
            mux_b   = vec[1];
            mux_sel = op;
        end else if (state == StIdle && manual) begin
            mux_a   = SW0;
            mux_b   = SW1;
            mux_sel = SW2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            op           <= 3'd0;
            vec          <= 2'd0;
            dwell        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            LED          <= 1'b0;
            table_out    <= 32'd0;
            mismatch_cnt <= 6'd0;
        end else begin
            LED  <= mux_y;
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start && !abort) begin
                        state        <= StApply;
                        busy         <= 1'b1;
                        table_out    <= 32'd0;
                        mismatch_cnt <= 6'd0;
                        op           <= 3'd0;
                        vec          <= 2'd0;
                        dwell        <= 8'd0;
                    end
                end
                StApply: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (dwell == LastDwell) begin
                        table_out[idx] <= mux_y;
                        if (mux_y != golden && mismatch_cnt != 6'h3f) begin
                            mismatch_cnt <= mismatch_cnt + 6'd1;
                        end
                        dwell <= 8'd0;
                        vec   <= vec + 2'd1;
                        if (vec == 2'd3) begin
                            op <= op + 3'd1;
                        end
                        if (op == 3'd7 && vec == 2'd3) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboarded bench: sweeps push expected tables, a done-driven monitor pops and compares.
module tb_gate_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        manual = 1'b0;
    logic        SW0 = 1'b0;
    logic        SW1 = 1'b0;
    logic [2:0]  SW2 = 3'd0;
    logic        mux_a, mux_b, mux_y, LED, busy, done;
    logic [2:0]  mux_sel;
    logic [31:0] table_out;
    logic [5:0]  mismatch_cnt;

    // 0 = working gate mux, 1 = stuck-at-0, 2 = stuck-at-1
    int mode = 0;

    typedef struct {
        logic [31:0] tbl;
        logic [5:0]  cnt;
        int          busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    gate_sweep_ctrl #(.STEP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .manual(manual),
        .SW0(SW0), .SW1(SW1), .SW2(SW2), .mux_a(mux_a), .mux_b(mux_b),
        .mux_sel(mux_sel), .mux_y(mux_y), .LED(LED), .busy(busy), .done(done),
        .table_out(table_out), .mismatch_cnt(mismatch_cnt)
    );

    function automatic logic gate_model(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0: return !a;
            3'd1: return a;
            3'd2: return a == b;
            3'd3: return a != b;
            3'd4: return a || b;
            3'd5: return !(a || b);
            3'd6: return a && b;
            default: return !(a && b);
        endcase
    endfunction

    assign mux_y = (mode == 0) ? gate_model(mux_sel, mux_a, mux_b) : (mode == 2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: measures busy length and compares captured results on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) busy_cnt = 0;
            if (busy) busy_cnt++;
            busy_prev = busy;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_table_out", table_out, e.tbl);
                    check("sb_mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
                    check("sb_busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
                    check("sb_busy_in_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs a full sweep; optionally raises start during the DONE cycle.
    task automatic sweep(input logic [31:0] tbl, input logic [5:0] cnt, input bit start_in_done);
        exp_t e;
        bit   seen;
        e.tbl = tbl;
        e.cnt = cnt;
        e.busy_cycles = 128;
        exp_q.push_back(e);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (i == 20) start = 1'b1;   // start while busy must be ignored
            else if (i == 21) start = 1'b0;
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            if (start_in_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_one_cycle", 32'(done), 32'd0);
            @(negedge clk);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_table", table_out, 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Manual pass-through in IDLE
        @(posedge clk); #1 manual = 1'b1; SW2 = 3'd3; SW0 = 1'b1; SW1 = 1'b0;
        @(negedge clk);
        check("manual_mux", 32'({mux_sel, mux_b, mux_a}), 32'({3'd3, 1'b0, 1'b1}));
        @(negedge clk);
        check("manual_led", 32'(LED), 32'd1);
        manual = 1'b0;
        #1 check("manual_off_mux", 32'({mux_sel, mux_b, mux_a}), 32'd0);

        // Start and abort together: abort wins
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", 32'(busy), 32'd0);

        // Working mux, with a stray start mid-sweep
        sweep(32'h781E69A5, 6'd0, 1'b0);
        // Stuck-at-0, plus start raised during DONE
        mode = 1;
        sweep(32'h00000000, 6'd16, 1'b1);
        repeat (3) @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        mode = 2;
        sweep(32'hFFFFFFFF, 6'd16, 1'b0);
        mode = 0;

        // Abort after 10 APPLY cycles; manual toggled during sweep
        manual = 1'b1; SW2 = 3'd7; SW0 = 1'b1; SW1 = 1'b1;
        pulse_start();
        @(negedge clk);
        check("sweep_ignores_manual", 32'({mux_sel, mux_b, mux_a}), 32'd0);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        manual = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_table", table_out, 32'h00000001);
        check("abort_cnt", 32'(mismatch_cnt), 32'd0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Reset at APPLY cycle 50, then a fresh full sweep
        pulse_start();
        repeat (49) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_vals", 32'({busy, done, LED, mismatch_cnt}), 32'd0);
        check("midrst_table", table_out, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_idle", 32'(busy), 32'd0);
        sweep(32'h781E69A5, 6'd0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
